// File: rtl/alu_md.sv
// alu_md: combinational EX-stage ALU plus a multi-cycle multiply/divide unit
// with architectural HI/LO registers and a start/busy handshake.
module alu_md #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic [WIDTH-1:0] C,
  input  logic [2:0]       md_op,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [SHW-1:0]   sh;
  logic             slt_s;
  logic             slt_u;

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic [WIDTH-1:0]   b_safe;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   abs_b_safe;
  logic [WIDTH-1:0]   uq;
  logic [WIDTH-1:0]   ur;
  logic [WIDTH-1:0]   sq;
  logic [WIDTH-1:0]   sr;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign sh    = B[SHW-1:0];
  assign slt_s = $signed(A) < $signed(B);
  assign slt_u = A < B;

  // Combinational ALU result; unused encodings produce zero.
  always_comb begin
    C = '0;
    case (ALUOp)
      4'd0:    C = A + B;
      4'd1:    C = A - B;
      4'd2:    C = A & B;
      4'd3:    C = A | B;
      4'd4:    C = A >> sh;
      4'd5:    C = $signed(A) >>> sh;
      4'd6:    C = A << sh;
      4'd7:    C = A ^ B;
      4'd8:    C = ~(A | B);
      4'd9:    C = {{(WIDTH-1){1'b0}}, slt_s};
      4'd10:   C = {{(WIDTH-1){1'b0}}, slt_u};
      default: C = '0;
    endcase
  end

  // Multiply/divide result from the captured operands. Signed division goes
  // through magnitudes so that truncation toward zero and dividend-signed
  // remainders fall out directly; the most-negative / -1 case also lands on
  // quotient = A, remainder = 0 through this path. Zero divisors are replaced
  // by one so the divider never sees zero; the result is overridden anyway.
  always_comb begin
    prod_s     = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod_u     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    b_safe     = (b_q == '0) ? WIDTH'(1) : b_q;
    abs_a      = a_q[WIDTH-1] ? -a_q : a_q;
    abs_b      = b_q[WIDTH-1] ? -b_q : b_q;
    abs_b_safe = (abs_b == '0) ? WIDTH'(1) : abs_b;
    uq         = a_q / b_safe;
    ur         = a_q % b_safe;
    sq         = abs_a / abs_b_safe;
    sr         = abs_a % abs_b_safe;
    if (a_q[WIDTH-1] ^ b_q[WIDTH-1]) sq = -sq;
    if (a_q[WIDTH-1]) sr = -sr;
    res_hi = '0;
    res_lo = '0;
    case (op_q)
      2'd0: {res_hi, res_lo} = prod_s;
      2'd1: {res_hi, res_lo} = prod_u;
      2'd2: begin
        if (b_q == '0) begin
          res_hi = a_q;
          res_lo = '1;
        end else begin
          res_hi = sr;
          res_lo = sq;
        end
      end
      default: begin
        if (b_q == '0) begin
          res_hi = a_q;
          res_lo = '1;
        end else begin
          res_hi = ur;
          res_lo = uq;
        end
      end
    endcase
  end

  // Next-state logic: accept only in IDLE, count down in RUN, write on the last edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (md_op)
            3'd0, 3'd1: begin
              state_d = RUN;
              cnt_d   = CW'(MUL_CYCLES);
              op_d    = md_op[1:0];
              a_d     = A;
              b_d     = B;
            end
            3'd2, 3'd3: begin
              state_d = RUN;
              cnt_d   = CW'(DIV_CYCLES);
              op_d    = md_op[1:0];
              a_d     = A;
              b_d     = B;
            end
            3'd4:    hi_d = A;
            3'd5:    lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, captured operands and HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
